// File: rtl/fpu_arbiter_if.sv
// Requester-side bus of the FPU arbiter: two request channels in, two response channels out.
// Valid/ready: a transfer happens on a rising edge where valid and the matching ready are both 1;
// the sender holds valid and payload stable until then, and ready may depend combinationally on valid.
interface fpu_arbiter_if #(
  parameter int OPW = 4
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [OPW-1:0] req_op0;
  logic [OPW-1:0] req_op1;
  logic [31:0]    req_a0;
  logic [31:0]    req_b0;
  logic [31:0]    req_a1;
  logic [31:0]    req_b1;
  logic [2:0]     req_rm0;
  logic [2:0]     req_rm1;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic [31:0]    resp_result;
  logic [4:0]     resp_flags;
  logic           resp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
           req_rm0, req_rm1, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_flags, resp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
           req_rm0, req_rm1, resp_ready,
    output req_ready, resp_valid, resp_result, resp_flags, resp_err
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between two requesters, one operation in flight,
// with a watchdog that answers with an error response if the FPU never signals done.
module fpu_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int OPW     = 4
) (
  input  logic            clk,
  input  logic            rst,
  fpu_arbiter_if.slave    bus,
  output logic            fpu_start,
  output logic [OPW-1:0]  fpu_op,
  output logic [31:0]     fpu_a,
  output logic [31:0]     fpu_b,
  output logic [2:0]      fpu_rm,
  input  logic            fpu_done,
  input  logic [31:0]     fpu_result,
  input  logic [4:0]      fpu_flags,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          gnt;
  logic          last;
  logic          pick;

  // On a tie the requester that was not served last wins; otherwise whoever asks.
  always_comb begin
    pick = bus.req_valid[1];
    if (&bus.req_valid) pick = ~last;
  end

  assign bus.req_ready = (!rst && state == IDLE && |bus.req_valid)
                         ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      gnt             <= 1'b0;
      last            <= 1'b1;
      fpu_start       <= 1'b0;
      fpu_op          <= '0;
      fpu_a           <= '0;
      fpu_b           <= '0;
      fpu_rm          <= '0;
      bus.resp_valid  <= 2'b00;
      bus.resp_result <= '0;
      bus.resp_flags  <= '0;
      bus.resp_err    <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            gnt       <= pick;
            last      <= pick;
            fpu_op    <= pick ? bus.req_op1 : bus.req_op0;
            fpu_a     <= pick ? bus.req_a1  : bus.req_a0;
            fpu_b     <= pick ? bus.req_b1  : bus.req_b0;
            fpu_rm    <= pick ? bus.req_rm1 : bus.req_rm0;
            fpu_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (fpu_done) begin
            bus.resp_result <= fpu_result;
            bus.resp_flags  <= fpu_flags;
            bus.resp_err    <= 1'b0;
            bus.resp_valid  <= gnt ? 2'b10 : 2'b01;
            state           <= RESP;
          end else if (cnt == CNT_MAX) begin
            bus.resp_result <= '0;
            bus.resp_flags  <= '0;
            bus.resp_err    <= 1'b1;
            bus.resp_valid  <= gnt ? 2'b10 : 2'b01;
            state           <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready[gnt]) begin
            bus.resp_valid <= 2'b00;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomized bench for fpu_arbiter: two requesters and a fake FPU feed a scoreboard that
// predicts grants, issue payloads, response timing and payloads from the arbitration rules.
module tb_fpu_arbiter;
  localparam int TIMEOUT = 8;
  localparam int OPW     = 4;
  localparam int NREQ    = 60;
  localparam int LIMIT   = 30000;
  localparam int IW      = 1 + OPW + 32 + 32 + 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  fpu_arbiter_if #(.OPW(OPW)) bus ();

  logic           rv0 = 1'b0, rv1 = 1'b0;
  logic [OPW-1:0] op0 = '0, op1 = '0;
  logic [31:0]    a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0]     rm0 = '0, rm1 = '0;
  logic [1:0]     rr = 2'b00;
  logic           fpu_start;
  logic [OPW-1:0] fpu_op;
  logic [31:0]    fpu_a, fpu_b;
  logic [2:0]     fpu_rm;
  logic           fpu_done = 1'b0;
  logic [31:0]    fpu_result = '0;
  logic [4:0]     fpu_flags = '0;
  logic [1:0]     dbg_state;

  assign bus.req_valid  = {rv1, rv0};
  assign bus.req_op0    = op0;
  assign bus.req_op1    = op1;
  assign bus.req_a0     = a0;
  assign bus.req_b0     = b0;
  assign bus.req_a1     = a1;
  assign bus.req_b1     = b1;
  assign bus.req_rm0    = rm0;
  assign bus.req_rm1    = rm1;
  assign bus.resp_ready = rr;

  fpu_arbiter #(.TIMEOUT(TIMEOUT), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fpu_start  (fpu_start),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_rm     (fpu_rm),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result),
    .fpu_flags  (fpu_flags),
    .dbg_state  (dbg_state)
  );

  // scoreboard state
  int tests = 0;
  int fails = 0;
  int resp_count = 0;
  int starts = 0;
  int accept_cyc = -10;
  logic m_last = 1'b1;
  logic [IW-1:0] iss_q[$];
  // {id, err, flags[4:0], result[31:0], first_valid_cycle[31:0]}
  logic [70:0]   exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one requester, holds each request until it is granted
  task automatic requester(input int r);
    int idle;
    int k;
    for (int n = 0; n < NREQ; n++) begin
      idle = (n == 0) ? 0 : $urandom_range(0, 3);
      repeat (idle) @(posedge clk);
      #1;
      if (r == 0) begin
        op0 = OPW'($urandom); a0 = $urandom; b0 = $urandom; rm0 = 3'($urandom_range(0, 7));
        rv0 = 1'b1;
      end else begin
        op1 = OPW'($urandom); a1 = $urandom; b1 = $urandom; rm1 = 3'($urandom_range(0, 7));
        rv1 = 1'b1;
      end
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus.req_ready[r] && k < 300);
      if (!bus.req_ready[r]) check("req_accept_bound", bus.req_ready[r], 1'b1);
      tick();
      if (r == 0) rv0 = 1'b0;
      else        rv1 = 1'b0;
    end
  endtask

  // driver: fake FPU, random latency; latencies past the limit give a stray late done
  task automatic responder();
    logic [IW-1:0] e;
    int d;
    logic [31:0] res;
    logic [4:0] fl;
    while (starts < 2 * NREQ && cyc < LIMIT) begin
      @(negedge clk);
      if (fpu_start) begin
        starts++;
        check("issue_expected", iss_q.size() != 0, 1'b1);
        if (iss_q.size() != 0) begin
          e = iss_q.pop_front();
          check("fpu_op", fpu_op, e[IW-2 -: OPW]);
          check("fpu_a",  fpu_a,  e[66:35]);
          check("fpu_b",  fpu_b,  e[34:3]);
          check("fpu_rm", fpu_rm, e[2:0]);
          d   = $urandom_range(0, TIMEOUT + 1);
          res = $urandom;
          fl  = 5'($urandom_range(0, 31));
          if (d <= TIMEOUT - 1)
            exp_q.push_back({e[IW-1], 1'b0, fl, res, 32'(cyc + d + 2)});
          else
            exp_q.push_back({e[IW-1], 1'b1, 5'd0, 32'd0, 32'(cyc + TIMEOUT + 1)});
          repeat (d + 1) @(posedge clk);
          #1;
          fpu_done = 1'b1; fpu_result = res; fpu_flags = fl;
          tick();
          fpu_done = 1'b0; fpu_result = $urandom; fpu_flags = 5'($urandom_range(0, 31));
        end
      end
    end
  endtask

  // driver: response back-pressure, including stalls and pulses on the wrong bit
  task automatic ready_driver();
    while (resp_count < 2 * NREQ && cyc < LIMIT) begin
      tick();
      if ($urandom_range(0, 7) == 0) begin
        rr = 2'b00;
        repeat (5) tick();
      end
      rr = 2'($urandom_range(0, 3));
    end
    rr = 2'b00;
  endtask

  // monitor: predicts grants from round-robin rules and checks every response
  task automatic monitor();
    logic [1:0] exp_rdy;
    logic g;
    logic m_busy;
    logic [70:0] e;
    m_busy = 1'b0;
    g = 1'b0;
    while (resp_count < 2 * NREQ && cyc < LIMIT) begin
      @(negedge clk);
      exp_rdy = 2'b00;
      if (!m_busy && (rv0 || rv1)) begin
        g = (rv0 && rv1) ? ~m_last : rv1;
        exp_rdy = g ? 2'b10 : 2'b01;
      end
      check("req_ready", bus.req_ready, exp_rdy);
      check("fpu_start_pulse", fpu_start, cyc == accept_cyc + 1);
      if (exp_rdy != 2'b00) begin
        m_busy = 1'b1;
        m_last = g;
        accept_cyc = cyc;
        iss_q.push_back(g ? {1'b1, op1, a1, b1, rm1} : {1'b0, op0, a0, b0, rm0});
      end
      if (exp_q.size() != 0 && cyc >= int'(exp_q[0][31:0])) begin
        e = exp_q[0];
        check("resp_valid",  bus.resp_valid, e[70] ? 2'b10 : 2'b01);
        check("resp_err",    bus.resp_err, e[69]);
        check("resp_flags",  bus.resp_flags, e[68:64]);
        check("resp_result", bus.resp_result, e[63:32]);
        if (rr[e[70]]) begin
          void'(exp_q.pop_front());
          m_busy = 1'b0;
          resp_count++;
        end
      end else begin
        check("resp_idle", bus.resp_valid, 2'b00);
      end
    end
    check("all_responses", resp_count, 2 * NREQ);
  endtask

  initial begin
    // reset values, with both requesters asking during reset
    rv0 = 1'b1; rv1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",   bus.req_ready, 2'b00);
    check("rst_fpu_start",   fpu_start, 1'b0);
    check("rst_resp_valid",  bus.resp_valid, 2'b00);
    check("rst_resp_result", bus.resp_result, 32'd0);
    check("rst_resp_flags",  bus.resp_flags, 5'd0);
    check("rst_resp_err",    bus.resp_err, 1'b0);
    check("rst_fpu_op",      fpu_op, '0);
    check("rst_fpu_a",       fpu_a, 32'd0);
    check("rst_fpu_b",       fpu_b, 32'd0);
    check("rst_fpu_rm",      fpu_rm, 3'd0);
    rv0 = 1'b0; rv1 = 1'b0;
    tick();
    rst = 1'b0;

    fork
      requester(0);
      requester(1);
      responder();
      ready_driver();
      monitor();
    join
    rr = 2'b00;
    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("iss_q_drained", iss_q.size(), 0);

    // requester 1 alone, then reset while waiting on the FPU; the late done must vanish
    op1 = 4'h5; a1 = 32'h3F80_0000; b1 = 32'h4000_0000; rm1 = 3'd0; rv1 = 1'b1;
    @(negedge clk);
    check("d_grant_r1", bus.req_ready, 2'b10);
    tick();
    rv1 = 1'b0;
    @(negedge clk);
    check("d_start", fpu_start, 1'b1);
    check("d_fpu_a", fpu_a, 32'h3F80_0000);
    check("d_fpu_b", fpu_b, 32'h4000_0000);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fpu_done = 1'b1; fpu_result = 32'h4040_0000; fpu_flags = 5'h01;
    @(negedge clk);
    tick();
    fpu_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("d_abort_resp_valid",  bus.resp_valid, 2'b00);
      check("d_abort_resp_result", bus.resp_result, 32'd0);
      check("d_abort_resp_flags",  bus.resp_flags, 5'd0);
      check("d_abort_resp_err",    bus.resp_err, 1'b0);
      check("d_abort_fpu_start",   fpu_start, 1'b0);
      check("d_abort_fpu_a",       fpu_a, 32'd0);
      check("d_abort_req_ready",   bus.req_ready, 2'b00);
      tick();
    end

    // tie right after reset goes to requester 0; FPU stays silent -> timeout response
    rv0 = 1'b1; rv1 = 1'b1;
    @(negedge clk);
    check("d_tie_r0", bus.req_ready, 2'b01);
    tick();
    rv0 = 1'b0; rv1 = 1'b0;
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      @(negedge clk);
      check("d_to_no_resp", bus.resp_valid, 2'b00);
    end
    @(negedge clk);
    check("d_to_resp_valid",  bus.resp_valid, 2'b01);
    check("d_to_resp_err",    bus.resp_err, 1'b1);
    check("d_to_resp_result", bus.resp_result, 32'd0);
    check("d_to_resp_flags",  bus.resp_flags, 5'd0);

    // back-pressure, wrong-bit ready, and no accept on the handshake cycle
    tick();
    rv1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("d_hold_valid", bus.resp_valid, 2'b01);
      check("d_hold_err",   bus.resp_err, 1'b1);
      check("d_hold_ready", bus.req_ready, 2'b00);
      tick();
    end
    rr = 2'b10;
    @(negedge clk);
    check("d_wrong_bit_valid", bus.resp_valid, 2'b01);
    tick();
    rr = 2'b01;
    @(negedge clk);
    check("d_hs_valid",     bus.resp_valid, 2'b01);
    check("d_hs_req_ready", bus.req_ready, 2'b00);
    tick();
    rr = 2'b00;
    @(negedge clk);
    check("d_after_hs_valid", bus.resp_valid, 2'b00);
    check("d_after_hs_grant", bus.req_ready, 2'b10);
    tick();
    rv1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, maximum cycles waited in WAIT for fpu_done before an error response.
REQ-002 Parameter: OPW, default 4, width of the operation code.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  2  per-requester request valid (bit 0 = requester 0).
REQ-006 Port: req_ready  output  2  per-requester request accept.
REQ-007 Port: req_op0, req_op1  input  OPW each  operation code.
REQ-008 Port: req_a0, req_b0, req_a1, req_b1  input  32 each  IEEE-754 single-precision operands.
REQ-009 Port: req_rm0, req_rm1  input  3 each  rounding mode.
REQ-010 Port: fpu_start  output  1  single-cycle start pulse to the shared FPU.
REQ-011 Port: fpu_op, fpu_a, fpu_b, fpu_rm  output  OPW/32/32/3  latched operation, operands and rounding mode, held stable from ISSUE until the next ISSUE.
REQ-012 Port: fpu_done  input  1  FPU result valid, one cycle.
REQ-013 Port: fpu_result  input  32  FPU result.
REQ-014 Port: fpu_flags  input  5  exception flags NV,DZ,OF,UF,NX.
REQ-015 Port: resp_valid  output  2  one-hot response valid to the originating requester.
REQ-016 Port: resp_ready  input  2  per-requester response accept.
REQ-017 Port: resp_result, resp_flags, resp_err  output  32/5/1  response payload shared by both requesters.

Function
REQ-018 The block SHALL be an FSM with states IDLE, ISSUE, WAIT, RESP, and SHALL allow exactly one FPU operation outstanding.
REQ-019 IDLE: if any req_valid is set, grant one requester; req_ready SHALL be asserted combinationally only for the granted requester and only in IDLE.
REQ-020 Arbitration SHALL be round-robin: when both request, grant the requester not served last; with one requesting, grant it regardless.
REQ-021 On the accept edge, latch op, operands, rm and grant ID, update last-served, and go to ISSUE.
REQ-022 ISSUE: fpu_start=1 for exactly one cycle; next state WAIT with the timeout counter cleared.
REQ-023 WAIT: counter increments every cycle; on fpu_done=1, latch fpu_result and fpu_flags, clear resp_err, go to RESP.
REQ-024 WAIT: if the counter reaches TIMEOUT-1 without fpu_done, go to RESP with resp_result=0, resp_flags=0, resp_err=1.
REQ-025 fpu_done and the counter limit in the same cycle: fpu_done SHALL win (no error).
REQ-026 fpu_done outside WAIT SHALL be ignored and SHALL NOT alter any state or payload.
REQ-027 RESP: resp_valid SHALL be set only at the bit of the granted ID, payload held stable, until the matching resp_ready=1; then return to IDLE.
REQ-028 resp_ready on the non-granted bit SHALL be ignored.
REQ-029 Minimum latency: accept at edge N, fpu_start high in cycle N+1, fpu_done earliest in cycle N+2, resp_valid from cycle N+3.
REQ-030 A new request SHALL NOT be accepted in the cycle the response handshake completes; acceptance resumes in IDLE the next cycle.

Reset
REQ-031 While rst=1, the block SHALL enter IDLE; req_ready=0, fpu_start=0, resp_valid=0, resp_result=0, resp_flags=0, resp_err=0, counter=0, and last-served = requester 1 (so requester 0 wins the first tie).
REQ-032 Reset asserted mid-operation (any state) SHALL abort it without a response; a later fpu_done SHALL be ignored per REQ-026.
REQ-033 fpu_op/a/b/rm SHALL reset to 0.

Verification
REQ-034 After reset, both req_valid=1 -> requester 0 granted (req_ready=2'b01); after its response, requests still pending -> requester 1 granted next.
REQ-035 Requester 1 alone, a=0x3F800000, b=0x40000000, fpu_done two cycles after fpu_start with result 0x40400000, flags 0 -> resp_valid=2'b10, resp_result=0x40400000, resp_err=0.
REQ-036 TIMEOUT=8, fpu_done never asserted -> resp_valid asserted 8 cycles after WAIT entry with resp_err=1, result 0.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP, pulse resp_ready on the wrong bit -> resp_valid and payload unchanged; correct bit -> IDLE next cycle.
REQ-038 Assert rst during WAIT, then fpu_done -> all outputs at reset values; no resp_valid.
REQ-039 Continuous requests from both requesters for 10 operations -> grants alternate 0,1,0,1,...; fpu_start pulses are exactly one cycle each.
